lsu_mem_responder: RTL and testbench
====================================

Name: lsu_mem_responder

Overview:
- Responder end of the per-thread LSU data-memory handshake; owns a single-port data scratchpad.
- Up to NUM_CONSUMERS compute-unit LSUs request reads or writes through packed valid/address/data buses.
- The block arbitrates round-robin, performs one access at a time with fixed latency, and returns one-cycle ready pulses (plus read data) to the granted LSU.
- Sits between the core's compute units and data storage; replaces a testbench memory model in core-level simulation.

Parameters:
- NUM_CONSUMERS, 4, number of LSU channels (one per thread).
- ADDR_BITS, 12, LSU address width.
- DATA_BITS, 16, data word width (Q1.15 payload; treated as opaque bits).
- MEM_ADDR_BITS, 8, implemented depth is 2**MEM_ADDR_BITS words.
- ACCESS_LATENCY, 2, cycles from grant edge to ready pulse; legal range 1..15.

Ports:
- clk  input  1  clock, all state on rising edge.
- reset  input  1  asynchronous, active-high reset.
- mem_read_valid  input  NUM_CONSUMERS  per-consumer read request.
- mem_read_address  input  NUM_CONSUMERS*ADDR_BITS  packed read addresses; consumer i at [i*ADDR_BITS +: ADDR_BITS].
- mem_read_ready  output  NUM_CONSUMERS  one-cycle read-complete pulse.
- mem_read_data  output  NUM_CONSUMERS*DATA_BITS  packed read data, per-consumer registered.
- mem_write_valid  input  NUM_CONSUMERS  per-consumer write request.
- mem_write_address  input  NUM_CONSUMERS*ADDR_BITS  packed write addresses.
- mem_write_data  input  NUM_CONSUMERS*DATA_BITS  packed write data.
- mem_write_ready  output  NUM_CONSUMERS  one-cycle write-complete pulse.
- busy  output  1  high while an access is in flight (state BUSY).
- range_error  output  1  sticky; set on any access with address >= 2**MEM_ADDR_BITS.

Behaviour:
- Reset (async, immediate): state IDLE, rr_ptr=0, served mask=0, latency counter=0. Outputs: mem_read_ready=0, mem_write_ready=0, all mem_read_data=0, busy=0, range_error=0. Storage array contents are not reset.
- Eligible consumer i: (mem_read_valid[i] | mem_write_valid[i]) & ~served[i].
- IDLE: if any consumer is eligible, pick the first eligible index searching from rr_ptr upward with wrap. Latch consumer index, op, address and write data. Go to BUSY with counter = ACCESS_LATENCY-1.
  - Op selection: write has priority if both valids are high on one consumer; that consumer's read is served in a later grant.
- BUSY: busy=1. Counter decrements each cycle. In the cycle counter==0:
  - Write: mem[addr] <= wdata.
  - Read: the consumer's read_data register <= mem[addr].
  - Pulse that consumer's ready for one cycle (registered).
  - Set served[i]; rr_ptr = (i+1) mod NUM_CONSUMERS; go to IDLE.
- Ready therefore rises exactly ACCESS_LATENCY cycles after the grant edge.
- Throughput is one access per ACCESS_LATENCY+1 cycles.
- Read data register persists until that consumer's next read completes. Other consumers' data registers are untouched.
- served[i] clears in any cycle where both mem_read_valid[i] and mem_write_valid[i] are low. This guarantees the LSU's held-high valid (after ready) is never re-served.
  - If valid stays high indefinitely, consumer i is never re-granted.
  - If a second op (read after priority write) is pending on the same consumer, it waits until valids drop. LSUs never issue both, so this is acceptable and documented.
- Latched request fields are stable during BUSY. Input changes mid-access have no effect on the in-flight access.
- Out-of-range address (upper ADDR_BITS-MEM_ADDR_BITS bits nonzero):
  - Write is dropped.
  - Read returns 0.
  - Ready still pulses normally.
  - range_error sets and remains 1 until reset.
- Reset mid-access aborts: no ready pulse, no memory write.
- At most one ready bit across both ready vectors is high in any cycle.

Test Plan:
- Single write then read: consumer 0 writes 0x1234 to addr 5, holds valid. Required: mem_write_ready[0] high exactly 2 cycles after grant, one cycle wide. Drop valid, then read addr 5: mem_read_ready[0] pulses and data[0]=0x1234.
- Held-valid no-repeat: after ready, keep mem_read_valid[0] high 10 cycles. Required: no further ready, busy=0. Drop then reassert: new access served.
- Round-robin fairness: all 4 consumers read simultaneously from rr_ptr=0. Required: grants 0,1,2,3 in order, ready pulses at 3-cycle spacing, each data register holds its own address's contents.
- Write priority: consumer 2 asserts read and write together. Required: write_ready[2] first. Read not served until both valids drop and read is re-requested.
- Out-of-range: read addr 0x100 (MEM_ADDR_BITS=8). Required: ready pulses, data=0, range_error=1 and stays 1. Subsequent in-range write to addr 0 succeeds.
- Reset mid-access: assert reset during BUSY before ready. Required: outputs zero immediately, no ready pulse, target word unchanged on later read.

Source files
------------

// File: rtl/lsu_mem_responder_if.sv
// LSU data-memory handshake bundle: packed per-consumer valid/address/data with
// one-cycle ready pulses back to each consumer.
interface lsu_mem_responder_if #(
    parameter int NUM_CONSUMERS = 4,
    parameter int ADDR_BITS     = 12,
    parameter int DATA_BITS     = 16
);
    logic [NUM_CONSUMERS-1:0]           mem_read_valid;
    logic [NUM_CONSUMERS*ADDR_BITS-1:0] mem_read_address;
    logic [NUM_CONSUMERS-1:0]           mem_read_ready;
    logic [NUM_CONSUMERS*DATA_BITS-1:0] mem_read_data;
    logic [NUM_CONSUMERS-1:0]           mem_write_valid;
    logic [NUM_CONSUMERS*ADDR_BITS-1:0] mem_write_address;
    logic [NUM_CONSUMERS*DATA_BITS-1:0] mem_write_data;
    logic [NUM_CONSUMERS-1:0]           mem_write_ready;

    modport master (
        output mem_read_valid, mem_read_address,
        output mem_write_valid, mem_write_address, mem_write_data,
        input  mem_read_ready, mem_read_data, mem_write_ready
    );

    modport slave (
        input  mem_read_valid, mem_read_address,
        input  mem_write_valid, mem_write_address, mem_write_data,
        output mem_read_ready, mem_read_data, mem_write_ready
    );
endinterface

// File: rtl/lsu_mem_responder.sv
// Round-robin responder for per-thread LSU requests in front of a single-port
// scratchpad; one fixed-latency access in flight at a time.
module lsu_mem_responder #(
    parameter int NUM_CONSUMERS  = 4,
    parameter int ADDR_BITS      = 12,
    parameter int DATA_BITS      = 16,
    parameter int MEM_ADDR_BITS  = 8,
    parameter int ACCESS_LATENCY = 2
) (
    input  logic                 clk,
    input  logic                 reset,
    lsu_mem_responder_if.slave   bus,
    output logic                 busy,
    output logic                 range_error
);
    localparam int PTR_W     = (NUM_CONSUMERS > 1) ? $clog2(NUM_CONSUMERS) : 1;
    localparam int MEM_DEPTH = 1 << MEM_ADDR_BITS;
    localparam logic [0:0] ST_IDLE = 1'b0;
    localparam logic [0:0] ST_BUSY = 1'b1;
    localparam logic [3:0] LAT_INIT = 4'(ACCESS_LATENCY - 1);

    logic [0:0]                         state_q, state_d;
    logic [PTR_W-1:0]                   rr_ptr_q, rr_ptr_d;
    logic [PTR_W-1:0]                   sel_q, sel_d;
    logic [PTR_W-1:0]                   grant_idx_s;
    logic                               grant_found_s;
    logic [NUM_CONSUMERS-1:0]           served_q, served_d;
    logic [NUM_CONSUMERS-1:0]           any_valid_s, eligible_s;
    logic [NUM_CONSUMERS-1:0]           read_ready_q, read_ready_d;
    logic [NUM_CONSUMERS-1:0]           write_ready_q, write_ready_d;
    logic [NUM_CONSUMERS*DATA_BITS-1:0] read_data_q, read_data_d;
    logic                               op_write_q, op_write_d;
    logic [ADDR_BITS-1:0]               addr_q, addr_d;
    logic [DATA_BITS-1:0]               wdata_q, wdata_d;
    logic [3:0]                         cnt_q, cnt_d;
    logic                               range_error_q, range_error_d;
    logic                               in_range_s;
    logic                               mem_we_s;
    logic [DATA_BITS-1:0]               mem_q [MEM_DEPTH];

    function automatic logic [PTR_W-1:0] wrap_idx(input logic [PTR_W-1:0] base, input int offset);
        int sum;
        sum = int'(base) + offset;
        sum = (sum >= NUM_CONSUMERS) ? (sum - NUM_CONSUMERS) : sum;
        return PTR_W'(sum);
    endfunction

    assign in_range_s = ((addr_q >> MEM_ADDR_BITS) == {ADDR_BITS{1'b0}});

    // Round-robin pick: scan downward so the nearest eligible index from rr_ptr wins.
    always_comb begin
        any_valid_s   = bus.mem_read_valid | bus.mem_write_valid;
        eligible_s    = any_valid_s & ~served_q;
        grant_found_s = |eligible_s;
        grant_idx_s   = rr_ptr_q;
        for (int k = NUM_CONSUMERS - 1; k >= 0; k--) begin
            grant_idx_s = eligible_s[wrap_idx(rr_ptr_q, k)] ? wrap_idx(rr_ptr_q, k) : grant_idx_s;
        end
    end

    // Access sequencing: latch on grant, count down, complete and pulse ready.
    always_comb begin
        state_d       = state_q;
        rr_ptr_d      = rr_ptr_q;
        sel_d         = sel_q;
        op_write_d    = op_write_q;
        addr_d        = addr_q;
        wdata_d       = wdata_q;
        cnt_d         = cnt_q;
        read_data_d   = read_data_q;
        range_error_d = range_error_q;
        read_ready_d  = '0;
        write_ready_d = '0;
        mem_we_s      = 1'b0;
        // A dropped request re-arms its consumer; a held-high valid stays masked.
        served_d      = served_q & any_valid_s;
        case (state_q)
            ST_IDLE: begin
                if (grant_found_s) begin
                    state_d    = ST_BUSY;
                    sel_d      = grant_idx_s;
                    op_write_d = bus.mem_write_valid[grant_idx_s];
                    addr_d     = bus.mem_write_valid[grant_idx_s]
                               ? bus.mem_write_address[grant_idx_s*ADDR_BITS +: ADDR_BITS]
                               : bus.mem_read_address[grant_idx_s*ADDR_BITS +: ADDR_BITS];
                    wdata_d    = bus.mem_write_data[grant_idx_s*DATA_BITS +: DATA_BITS];
                    cnt_d      = LAT_INIT;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_BUSY: begin
                if (cnt_q == 4'd0) begin
                    state_d         = ST_IDLE;
                    served_d[sel_q] = 1'b1;
                    rr_ptr_d        = (sel_q == PTR_W'(NUM_CONSUMERS - 1)) ? '0 : sel_q + PTR_W'(1);
                    range_error_d   = range_error_q | ~in_range_s;
                    if (op_write_q) begin
                        write_ready_d[sel_q] = 1'b1;
                        mem_we_s             = in_range_s;
                    end else begin
                        read_ready_d[sel_q] = 1'b1;
                        read_data_d[sel_q*DATA_BITS +: DATA_BITS] =
                            in_range_s ? mem_q[addr_q[MEM_ADDR_BITS-1:0]] : {DATA_BITS{1'b0}};
                    end
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Control and output registers; reset aborts any in-flight access.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q       <= ST_IDLE;
            rr_ptr_q      <= '0;
            sel_q         <= '0;
            served_q      <= '0;
            op_write_q    <= 1'b0;
            addr_q        <= '0;
            wdata_q       <= '0;
            cnt_q         <= 4'd0;
            read_ready_q  <= '0;
            write_ready_q <= '0;
            read_data_q   <= '0;
            range_error_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            rr_ptr_q      <= rr_ptr_d;
            sel_q         <= sel_d;
            served_q      <= served_d;
            op_write_q    <= op_write_d;
            addr_q        <= addr_d;
            wdata_q       <= wdata_d;
            cnt_q         <= cnt_d;
            read_ready_q  <= read_ready_d;
            write_ready_q <= write_ready_d;
            read_data_q   <= read_data_d;
            range_error_q <= range_error_d;
        end
    end

    // Storage array is deliberately left unreset.
    always_ff @(posedge clk) begin
        if (mem_we_s) begin
            mem_q[addr_q[MEM_ADDR_BITS-1:0]] <= wdata_q;
        end
    end

    assign bus.mem_read_ready  = read_ready_q;
    assign bus.mem_write_ready = write_ready_q;
    assign bus.mem_read_data   = read_data_q;
    assign busy                = (state_q == ST_BUSY);
    assign range_error         = range_error_q;
endmodule

// File: tb/tb_lsu_mem_responder.sv
// Scoreboard bench for lsu_mem_responder: stimulus predicts responses into a queue,
// a negedge monitor pops and compares on every ready pulse.
module tb_lsu_mem_responder;
    localparam int N   = 4;
    localparam int AB  = 12;
    localparam int DB  = 16;
    localparam int MAB = 8;

    logic clk = 1'b0;
    logic reset;
    logic busy;
    logic range_error;

    always #5 clk = ~clk;

    lsu_mem_responder_if #(.NUM_CONSUMERS(N), .ADDR_BITS(AB), .DATA_BITS(DB)) bus();

    lsu_mem_responder #(
        .NUM_CONSUMERS(N), .ADDR_BITS(AB), .DATA_BITS(DB),
        .MEM_ADDR_BITS(MAB), .ACCESS_LATENCY(2)
    ) dut (
        .clk(clk),
        .reset(reset),
        .bus(bus),
        .busy(busy),
        .range_error(range_error)
    );

    typedef struct {
        bit            is_wr;
        int            c;
        logic [DB-1:0] data;
        bit            rerr;
    } exp_t;

    exp_t          exp_q[$];
    int            n_checks = 0;
    int            n_fail   = 0;
    logic [DB-1:0] mem_model [256];
    bit            written   [256];
    int            rr_model;
    bit            rerr_model;
    logic [DB-1:0] rdata_model [N];
    bit            req_rd [N];
    bit            req_wr [N];
    logic [AB-1:0] req_raddr [N];
    logic [AB-1:0] req_waddr [N];
    logic [DB-1:0] req_wdata [N];
    int            stamp_q[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h required 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Monitor: every ready pulse must match the oldest predicted response.
    exp_t mon_e;
    int   mon_c;
    bit   mon_wr;
    always @(negedge clk) begin
        if (!reset && ((bus.mem_read_ready | bus.mem_write_ready) != '0)) begin
            check("ready_onehot", $countones({bus.mem_read_ready, bus.mem_write_ready}), 1);
            mon_c  = 0;
            mon_wr = 1'b0;
            for (int i = 0; i < N; i++) begin
                if (bus.mem_read_ready[i])  begin mon_c = i; mon_wr = 1'b0; end
                if (bus.mem_write_ready[i]) begin mon_c = i; mon_wr = 1'b1; end
            end
            if (exp_q.size() == 0) begin
                check("unexpected_ready", {24'd0, bus.mem_read_ready, bus.mem_write_ready}, 0);
            end else begin
                mon_e = exp_q.pop_front();
                check("ready_consumer", mon_c, mon_e.c);
                check("ready_op_is_write", {31'd0, mon_wr}, {31'd0, mon_e.is_wr});
                if (!mon_e.is_wr) rdata_model[mon_e.c] = mon_e.data;
                for (int i = 0; i < N; i++)
                    check($sformatf("read_data[%0d]", i), {16'd0, bus.mem_read_data[i*DB +: DB]}, {16'd0, rdata_model[i]});
                check("range_error", {31'd0, range_error}, {31'd0, mon_e.rerr});
            end
        end
    end

    // Reference: grants go to requesters in circular order from the pointer.
    task automatic predict();
        int last;
        last = -1;
        for (int k = 0; k < N; k++) begin
            int   c;
            exp_t e;
            bit   oor;
            c = (rr_model + k) % N;
            if (req_rd[c] || req_wr[c]) begin
                e.c    = c;
                e.data = '0;
                if (req_wr[c]) begin
                    e.is_wr = 1'b1;
                    oor = (req_waddr[c] >= 256);
                    if (!oor) begin
                        mem_model[req_waddr[c][7:0]] = req_wdata[c];
                        written[req_waddr[c][7:0]]   = 1'b1;
                    end
                end else begin
                    e.is_wr = 1'b0;
                    oor = (req_raddr[c] >= 256);
                    e.data = oor ? '0 : mem_model[req_raddr[c][7:0]];
                end
                rerr_model = rerr_model | oor;
                e.rerr     = rerr_model;
                exp_q.push_back(e);
                last = c;
            end
        end
        if (last >= 0) rr_model = (last + 1) % N;
    endtask

    task automatic clear_req();
        for (int i = 0; i < N; i++) begin
            req_rd[i] = 1'b0; req_wr[i] = 1'b0;
            req_raddr[i] = '0; req_waddr[i] = '0; req_wdata[i] = '0;
        end
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic drop_all();
        bus.mem_read_valid  = '0;
        bus.mem_write_valid = '0;
    endtask

    // Issue the current request set at a negedge and wait for every requester's ready.
    task automatic run_batch(input bit drop, input int budget);
        logic [N-1:0] pending;
        int cyc;
        predict();
        stamp_q.delete();
        pending = '0;
        for (int i = 0; i < N; i++) begin
            bus.mem_read_valid[i]            = req_rd[i];
            bus.mem_write_valid[i]           = req_wr[i];
            bus.mem_read_address[i*AB +: AB]  = req_raddr[i];
            bus.mem_write_address[i*AB +: AB] = req_waddr[i];
            bus.mem_write_data[i*DB +: DB]    = req_wdata[i];
            pending[i] = req_rd[i] | req_wr[i];
        end
        cyc = 0;
        while (pending != '0 && cyc < budget) begin
            @(negedge clk);
            cyc++;
            for (int i = 0; i < N; i++) begin
                if (bus.mem_read_ready[i] || bus.mem_write_ready[i]) begin
                    pending[i] = 1'b0;
                    stamp_q.push_back(cyc);
                    if (drop) begin
                        bus.mem_read_valid[i]  = 1'b0;
                        bus.mem_write_valid[i] = 1'b0;
                    end
                end
            end
        end
        check("batch_complete", {28'd0, pending}, 0);
    endtask

    initial begin
        reset = 1'b1;
        bus.mem_read_valid = '0;   bus.mem_write_valid = '0;
        bus.mem_read_address = '0; bus.mem_write_address = '0;
        bus.mem_write_data = '0;
        rr_model = 0; rerr_model = 1'b0;
        for (int i = 0; i < N; i++) rdata_model[i] = '0;
        for (int a = 0; a < 256; a++) begin mem_model[a] = '0; written[a] = 1'b0; end
        clear_req();
        idle(2);
        check("reset_ready", {24'd0, bus.mem_read_ready, bus.mem_write_ready}, 0);
        check("reset_data_zero", {31'd0, bus.mem_read_data != '0}, 0);
        check("reset_busy", {31'd0, busy}, 0);
        check("reset_range_error", {31'd0, range_error}, 0);
        reset = 1'b0;
        idle(2);

        // Single write then read, with latency and pulse width.
        req_wr[0] = 1'b1; req_waddr[0] = 12'h005; req_wdata[0] = 16'h1234;
        run_batch(1'b1, 50);
        check("t1_write_latency", stamp_q.size() > 0 ? stamp_q[0] : -1, 3);
        @(negedge clk);
        check("t1_pulse_width", {28'd0, bus.mem_write_ready}, 0);
        idle(1);
        clear_req();
        req_rd[0] = 1'b1; req_raddr[0] = 12'h005;
        run_batch(1'b0, 50);

        // Held-high valid must not be served again.
        repeat (10) begin
            @(negedge clk);
            check("held_busy", {31'd0, busy}, 0);
            check("held_no_ready", {28'd0, bus.mem_read_ready}, 0);
        end
        drop_all();
        idle(2);
        run_batch(1'b1, 50);
        idle(2);

        // Write priority when both valids are high on one consumer.
        clear_req();
        req_wr[2] = 1'b1; req_waddr[2] = 12'h014; req_wdata[2] = 16'hBEEF;
        req_rd[2] = 1'b1; req_raddr[2] = 12'h014;
        run_batch(1'b0, 50);
        repeat (10) begin
            @(negedge clk);
            check("prio_read_waits", {28'd0, bus.mem_read_ready}, 0);
            check("prio_busy", {31'd0, busy}, 0);
        end
        drop_all();
        idle(2);
        clear_req();
        req_rd[2] = 1'b1; req_raddr[2] = 12'h014;
        run_batch(1'b1, 50);
        idle(2);

        // Out-of-range read, then in-range traffic with a sticky error flag.
        clear_req();
        req_rd[3] = 1'b1; req_raddr[3] = 12'h100;
        run_batch(1'b1, 50);
        idle(3);
        check("oor_sticky", {31'd0, range_error}, 1);
        clear_req();
        req_wr[0] = 1'b1; req_waddr[0] = 12'h000; req_wdata[0] = 16'h0F0F;
        run_batch(1'b1, 50);
        idle(2);
        clear_req();
        req_rd[0] = 1'b1; req_raddr[0] = 12'h000;
        run_batch(1'b1, 50);
        idle(2);
        check("oor_still_sticky", {31'd0, range_error}, 1);

        // Reset in the middle of an access.
        clear_req();
        req_wr[1] = 1'b1; req_waddr[1] = 12'h009; req_wdata[1] = 16'hAAAA;
        run_batch(1'b1, 50);
        idle(2);
        bus.mem_write_valid[1]          = 1'b1;
        bus.mem_write_address[1*AB +: AB] = 12'h009;
        bus.mem_write_data[1*DB +: DB]    = 16'h5555;
        @(negedge clk);
        check("abort_busy_before", {31'd0, busy}, 1);
        reset = 1'b1;
        #1;
        check("abort_ready", {24'd0, bus.mem_read_ready, bus.mem_write_ready}, 0);
        check("abort_busy", {31'd0, busy}, 0);
        check("abort_data_zero", {31'd0, bus.mem_read_data != '0}, 0);
        check("abort_range_error", {31'd0, range_error}, 0);
        rr_model = 0; rerr_model = 1'b0;
        for (int i = 0; i < N; i++) rdata_model[i] = '0;
        drop_all();
        idle(2);
        reset = 1'b0;
        repeat (6) begin
            @(negedge clk);
            check("abort_no_ready", {24'd0, bus.mem_read_ready, bus.mem_write_ready}, 0);
        end
        clear_req();
        req_rd[3] = 1'b1; req_raddr[3] = 12'h009;
        run_batch(1'b1, 50);
        idle(2);

        // Round-robin fairness from pointer 0 with 3-cycle spacing.
        clear_req();
        req_rd[0] = 1'b1; req_raddr[0] = 12'h005;
        req_rd[1] = 1'b1; req_raddr[1] = 12'h014;
        req_rd[2] = 1'b1; req_raddr[2] = 12'h000;
        req_rd[3] = 1'b1; req_raddr[3] = 12'h009;
        run_batch(1'b1, 60);
        for (int k = 0; k < N; k++)
            check($sformatf("rr_stamp[%0d]", k), stamp_q.size() > k ? stamp_q[k] : -1, 3 * (k + 1));
        idle(2);

        // Randomized batches against the reference model.
        for (int b = 0; b < 40; b++) begin
            clear_req();
            for (int i = 0; i < N; i++) begin
                if ($urandom_range(3, 0) != 0) begin
                    logic [AB-1:0] a;
                    bit            oor;
                    oor = ($urandom_range(7, 0) == 0);
                    a = oor ? AB'($urandom_range(12'hFFF, 12'h100)) : AB'($urandom_range(15, 0));
                    if ($urandom_range(1, 0) == 1 || (!oor && !written[a[7:0]])) begin
                        req_wr[i] = 1'b1; req_waddr[i] = a; req_wdata[i] = DB'($urandom);
                    end else begin
                        req_rd[i] = 1'b1; req_raddr[i] = a;
                    end
                end
            end
            run_batch(1'b1, 60);
            idle(2);
        end

        idle(5);
        check("scoreboard_empty", exp_q.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
